// File: rtl/fifo_rr_arb_pkg.sv
// Types and helpers shared by the round-robin FIFO arbiter and its picker.
package fifo_rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Explicit wrap so the pointer stays legal for non-power-of-2 requester counts.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/prim_util_pkg.sv
// Shared sizing helpers for the primitive library.
package prim_util_pkg;

  // Bits needed to index `value` items; a single item still needs one bit.
  function automatic integer vbits(integer value);
    return (value == 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fifo_rr_arb_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping at N.
module fifo_rr_arb_pick
  import fifo_rr_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = prim_util_pkg::vbits(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // NOTE: every variable gets a default before the search so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/prim_fifo_sync.sv
// Synchronous valid/ready FIFO with optional pass-through, flush and under-reset write blocking.
module prim_fifo_sync #(
  parameter int unsigned Width             = 16,
  parameter bit          Pass              = 1'b1,
  parameter int unsigned Depth             = 4,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  parameter bit          Secure            = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             err_o
);

  localparam int unsigned PtrW = prim_util_pkg::vbits(Depth);
  localparam int unsigned CntW = prim_util_pkg::vbits(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             under_rst_q;
  logic             empty, full, bypass, wr_en, rd_en;
  logic [Width-1:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign bypass   = Pass & empty;
  // Writes stay blocked for the first cycle after reset release.
  assign wready_o = ~full & ~under_rst_q;
  assign rvalid_o = bypass ? (wvalid_i & ~under_rst_q) : ~empty;
  assign wr_en    = wvalid_i & wready_o & ~(bypass & rready_i);
  assign rd_en    = rvalid_o & rready_i & ~bypass;
  assign head     = bypass ? wdata_i : mem_q[rptr_q];
  assign rdata_o  = (OutputZeroIfEmpty && !rvalid_o) ? '0 : head;
  assign err_o    = Secure && (32'(count_q) > Depth);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      under_rst_q <= 1'b1;
    end else begin
      under_rst_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= ptr_inc(wptr_q);
      if (rd_en) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count decide what
  // is valid, and OutputZeroIfEmpty hides stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fifo_rr_arb.sv
// N buffered requesters sharing one valid/ready sink under a burst-bounded round-robin grant.
module fifo_rr_arb
  import fifo_rr_arb_pkg::*;
#(
  parameter  int unsigned N         = 4,
  parameter  int unsigned Width     = 16,
  parameter  int unsigned FifoDepth = 2,
  parameter  int unsigned MaxBurst  = 4,
  localparam int unsigned IdxW      = prim_util_pkg::vbits(N),
  localparam int unsigned BeatW     = prim_util_pkg::vbits(MaxBurst)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic [N-1:0]          req_valid_i,
  output logic [N-1:0]          req_ready_o,
  input  logic [N-1:0][Width-1:0] req_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [Width-1:0]      out_data_o,
  output logic [IdxW-1:0]       out_idx_o,
  output logic [N-1:0]          gnt_o,
  output logic                  busy_o,
  output logic                  err_o
);

  logic [N-1:0]            fifo_rvalid, fifo_rready, fifo_err;
  logic [N-1:0][Width-1:0] fifo_rdata;

  for (genvar i = 0; i < N; i++) begin : g_fifo
    prim_fifo_sync #(
      .Width            (Width),
      .Pass             (1'b0),
      .Depth            (FifoDepth),
      .OutputZeroIfEmpty(1'b1),
      .Secure           (1'b0)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .wvalid_i(req_valid_i[i]),
      .wready_o(req_ready_o[i]),
      .wdata_i (req_data_i[i]),
      .rvalid_o(fifo_rvalid[i]),
      .rready_i(fifo_rready[i]),
      .rdata_o (fifo_rdata[i]),
      .err_o   (fifo_err[i])
    );
  end

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            head_valid, handshake;

  fifo_rr_arb_pick #(.N(N)) u_pick (
    .req  (fifo_rvalid),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    fifo_rready = '0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    gnt_o       = '0;
    head_valid  = 1'b0;
    handshake   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_idx_d = pick_idx;
          beat_d    = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        head_valid             = fifo_rvalid[gnt_idx_q];
        handshake              = head_valid & out_ready_i;
        out_valid_o            = head_valid;
        out_data_o             = fifo_rdata[gnt_idx_q];
        gnt_o[gnt_idx_q]       = 1'b1;
        fifo_rready[gnt_idx_q] = out_ready_i;
        if (handshake) beat_d = beat_q + 1'b1;
        // Release on a full burst or once the granted FIFO has drained.
        if ((handshake && beat_q == BeatW'(MaxBurst - 1)) || !head_valid) begin
          state_d  = IDLE;
          rr_ptr_d = IdxW'(rr_next(32'(gnt_idx_q), N));
          beat_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any transition; the beat handshaken this cycle still leaves.
    if (clr_i) begin
      state_d   = IDLE;
      gnt_idx_d = '0;
      rr_ptr_d  = '0;
      beat_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
    end
  end

  assign out_idx_o = gnt_idx_q;
  assign busy_o    = (|fifo_rvalid) | (state_q == GRANT);
  assign err_o     = |fifo_err;

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Directed bench for fifo_rr_arb (N=4, Width=16, FifoDepth=2, MaxBurst=4).
module tb_fifo_rr_arb;

  localparam int N = 4;
  localparam int W = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              clr_i = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0][W-1:0] req_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [W-1:0]      out_data_o;
  logic [1:0]        out_idx_o;
  logic [N-1:0]      gnt_o;
  logic              busy_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  fifo_rr_arb #(.N(N), .Width(W), .FifoDepth(2), .MaxBurst(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i (req_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_idx_o  (out_idx_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) tick();
    mid();
    checks++; if ({out_valid_o, out_data_o, out_idx_o, gnt_o} !== '0) begin errors++; $display("FAIL reset_outputs: got v=%b d=%h idx=%0d gnt=%b want all zero", out_valid_o, out_data_o, out_idx_o, gnt_o); end
    checks++; if ({busy_o, err_o} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0 0", busy_o, err_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready_low: got %b want 0000", req_ready_o); end
    #2 rst_ni = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready_first_cycle: got %b want 0000", req_ready_o); end
    tick();
    mid();
    checks++; if (req_ready_o !== 4'b1111) begin errors++; $display("FAIL reset_ready_after: got %b want 1111", req_ready_o); end
  endtask

  task automatic test_single();
    tick(); req_valid_i = 4'b0001; req_data_i[0] = 16'h00A1; out_ready_i = 1'b1; mid();
    checks++; if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL single_ready_t: got %b want 1", req_ready_o[0]); end
    tick(); req_data_i[0] = 16'h00A2; mid();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_t1: got %b want 0", out_valid_o); end
    tick(); req_data_i[0] = 16'h00A3; mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h00A1) begin errors++; $display("FAIL single_beat0: got v=%b d=%h want v=1 d=00a1", out_valid_o, out_data_o); end
    checks++; if (out_idx_o !== 2'd0 || gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt: got idx=%0d gnt=%b want idx=0 gnt=0001", out_idx_o, gnt_o); end
    checks++; if (req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL single_full: got %b want 0", req_ready_o[0]); end
    tick(); mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h00A2) begin errors++; $display("FAIL single_beat1: got v=%b d=%h want v=1 d=00a2", out_valid_o, out_data_o); end
    tick(); req_valid_i = '0; mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'h00A3 || gnt_o !== 4'b0001) begin errors++; $display("FAIL single_beat2: got v=%b d=%h gnt=%b want v=1 d=00a3 gnt=0001", out_valid_o, out_data_o, gnt_o); end
    tick(); mid();
    checks++; if (out_valid_o !== 1'b0 || gnt_o !== 4'b0001) begin errors++; $display("FAIL single_drain: got v=%b gnt=%b want v=0 gnt=0001", out_valid_o, gnt_o); end
    tick(); mid();
    checks++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got gnt=%b busy=%b want 0000 0", gnt_o, busy_o); end
  endtask

  task automatic test_fairness();
    int seq [N];
    logic [N-1:0] rdy;
    logic [W-1:0] exp_data;
    int rel, g, k;
    for (int i = 0; i < N; i++) seq[i] = 0;
    tick(); clr_i = 1'b1; req_valid_i = '0; mid();
    for (int cyc = 0; cyc < 27; cyc++) begin
      tick(); clr_i = 1'b0; req_valid_i = '1;
      for (int i = 0; i < N; i++) req_data_i[i] = {4'(i), 12'(seq[i])};
      mid();
      rdy = req_ready_o;
      if (cyc >= 2) begin
        rel = cyc - 2; g = rel / 5; k = rel % 5;
        if (k < 4) begin
          exp_data = {4'(g % 4), 12'((g / 4) * 4 + k)};
          checks++; if (out_valid_o !== 1'b1 || out_idx_o !== 2'(g % 4) || gnt_o !== 4'(1 << (g % 4)) || out_data_o !== exp_data) begin errors++; $display("FAIL fair_beat c%0d: got v=%b idx=%0d gnt=%b d=%h want v=1 idx=%0d d=%h", cyc, out_valid_o, out_idx_o, gnt_o, out_data_o, g % 4, exp_data); end
        end else begin
          checks++; if (out_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("FAIL fair_gap c%0d: got v=%b gnt=%b want v=0 gnt=0000", cyc, out_valid_o, gnt_o); end
        end
      end
      for (int i = 0; i < N; i++) if (rdy[i]) seq[i]++;
    end
    tick(); req_valid_i = '0; clr_i = 1'b1; mid();
    tick(); clr_i = 1'b0; mid();
  endtask

  task automatic test_backpressure();
    tick(); out_ready_i = 1'b0; req_valid_i = 4'b0010; req_data_i[1] = 16'hB001; mid();
    tick(); req_valid_i = '0; mid();
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid_i = (k == 1) ? 4'b0010 : 4'b0000;
      req_data_i[1] = 16'hB002;
      mid();
      checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'hB001 || out_idx_o !== 2'd1 || gnt_o !== 4'b0010) begin errors++; $display("FAIL bp_hold k%0d: got v=%b d=%h idx=%0d gnt=%b want v=1 d=b001 idx=1 gnt=0010", k, out_valid_o, out_data_o, out_idx_o, gnt_o); end
      checks++; if (req_ready_o[1] !== (k < 2)) begin errors++; $display("FAIL bp_ready k%0d: got %b want %b", k, req_ready_o[1], (k < 2)); end
    end
    tick(); req_valid_i = '0; out_ready_i = 1'b1; mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'hB001) begin errors++; $display("FAIL bp_beat0: got v=%b d=%h want v=1 d=b001", out_valid_o, out_data_o); end
    tick(); mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'hB002 || req_ready_o[1] !== 1'b1) begin errors++; $display("FAIL bp_beat1: got v=%b d=%h rdy=%b want v=1 d=b002 rdy=1", out_valid_o, out_data_o, req_ready_o[1]); end
    tick(); mid();
    checks++; if (out_valid_o !== 1'b0 || gnt_o !== 4'b0010) begin errors++; $display("FAIL bp_drain: got v=%b gnt=%b want v=0 gnt=0010", out_valid_o, gnt_o); end
    tick(); mid();
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL bp_idle: got gnt=%b want 0000", gnt_o); end
  endtask

  task automatic test_early_release();
    logic [8:0]   exp_v   = 9'b0_0100_1001;  // bit i is cycle i+2
    logic [3:0]   exp_gnt [9];
    logic [W-1:0] exp_d   [9];
    exp_gnt = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    exp_d   = '{16'hC002, 16'h0000, 16'h0000, 16'hC003, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 16'h0000};
    tick(); req_valid_i = 4'b1101;
    req_data_i[0] = 16'hC000; req_data_i[2] = 16'hC002; req_data_i[3] = 16'hC003;
    mid();
    tick(); req_valid_i = '0; mid();
    for (int c = 0; c < 9; c++) begin
      tick(); mid();
      checks++; if (out_valid_o !== exp_v[c] || gnt_o !== exp_gnt[c] || out_data_o !== exp_d[c]) begin errors++; $display("FAIL early c%0d: got v=%b gnt=%b d=%h want v=%b gnt=%b d=%h", c + 2, out_valid_o, gnt_o, out_data_o, exp_v[c], exp_gnt[c], exp_d[c]); end
    end
    checks++; if (busy_o !== 1'b0 || out_idx_o !== 2'd0) begin errors++; $display("FAIL early_end: got busy=%b idx=%0d want 0 0", busy_o, out_idx_o); end
  endtask

  task automatic test_flush();
    tick(); out_ready_i = 1'b0; req_valid_i = 4'b0010; req_data_i[1] = 16'hD001; mid();
    tick(); req_data_i[1] = 16'hD002; mid();
    tick(); req_valid_i = '0; out_ready_i = 1'b1; clr_i = 1'b1; mid();
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 16'hD001) begin errors++; $display("FAIL flush_last_beat: got v=%b d=%h want v=1 d=d001", out_valid_o, out_data_o); end
    tick(); clr_i = 1'b0; mid();
    checks++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after: got gnt=%b busy=%b v=%b want 0000 0 0", gnt_o, busy_o, out_valid_o); end
    for (int c = 0; c < 4; c++) begin
      tick(); mid();
      checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_stale c%0d: got v=%b busy=%b d=%h want v=0 busy=0", c, out_valid_o, busy_o, out_data_o); end
    end
    tick(); req_valid_i = 4'b0011; req_data_i[0] = 16'hF000; req_data_i[1] = 16'hF001; mid();
    tick(); req_valid_i = '0; mid();
    tick(); mid();
    checks++; if (out_valid_o !== 1'b1 || out_idx_o !== 2'd0 || out_data_o !== 16'hF000) begin errors++; $display("FAIL flush_ptr_reset: got v=%b idx=%0d d=%h want v=1 idx=0 d=f000", out_valid_o, out_idx_o, out_data_o); end
    repeat (3) begin tick(); mid(); end
    checks++; if (out_valid_o !== 1'b1 || out_idx_o !== 2'd1 || out_data_o !== 16'hF001) begin errors++; $display("FAIL flush_next: got v=%b idx=%0d d=%h want v=1 idx=1 d=f001", out_valid_o, out_idx_o, out_data_o); end
    repeat (2) begin tick(); mid(); end
  endtask

  task automatic test_reset_midburst();
    tick(); out_ready_i = 1'b0; req_valid_i = 4'b0100; req_data_i[2] = 16'hE002; mid();
    tick(); req_valid_i = '0; mid();
    tick(); mid();
    checks++; if (out_valid_o !== 1'b1 || out_idx_o !== 2'd2) begin errors++; $display("FAIL rst_mid_pre: got v=%b idx=%0d want v=1 idx=2", out_valid_o, out_idx_o); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if ({out_valid_o, out_data_o, out_idx_o, gnt_o, busy_o} !== '0 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_async: got v=%b d=%h idx=%0d gnt=%b busy=%b rdy=%b want all zero", out_valid_o, out_data_o, out_idx_o, gnt_o, busy_o, req_ready_o); end
    tick(); tick();
    rst_ni = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_flush();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
